cell_fetch: RTL and testbench



---
 rtl/cell_fetch.sv | 139 +++++++++++++
 tb/tb_cell_fetch.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : cell_fetch
//  Purpose  : Fetches a two-word cell (header at ptr, value at ptr+1) from a
//             synchronous-read ROM and returns mark/type/value over a
//             valid/ready response channel.
//  Revision : 1.0  initial release
// ============================================================================
module cell_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TYPE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_ptr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_ptr,
    output logic                  rsp_mark,
    output logic [TYPE_WIDTH-1:0] rsp_type,
    output logic [DATA_WIDTH-1:0] rsp_value
);

    // Increment used for the value-word address; wraps naturally at 2^ADDR_WIDTH.
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // One state per cycle of the fetch: address header, capture header,
    // capture value, then hold the response until it is taken.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_HDR = 3'd1,
        CAP_HDR  = 3'd2,
        CAP_VAL  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_req_ready;

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_rsp_ptr;
    logic                  r_rsp_mark;
    logic [TYPE_WIDTH-1:0] r_rsp_type;
    logic [DATA_WIDTH-1:0] r_rsp_value;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; req_ready is purely a decode of the current state.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = ADDR_HDR;
                end
            end
            ADDR_HDR: w_state_next = CAP_HDR;
            CAP_HDR:  w_state_next = CAP_VAL;
            CAP_VAL:  w_state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default:  w_state_next = IDLE;
        endcase
    end

    // Datapath: drive ROM address, capture the two ROM words one cycle after
    // each address is presented, and hold the response until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_ptr   <= '0;
            r_rsp_mark  <= 1'b0;
            r_rsp_type  <= '0;
            r_rsp_value <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_ptr      <= req_ptr;
                        r_mem_addr <= req_ptr;
                    end
                end
                ADDR_HDR: begin
                    r_mem_addr <= r_ptr + c_addr_one;
                end
                CAP_HDR: begin
                    // Header bits between the type tag and the mark are unused.
                    r_rsp_mark <= mem_rdata[DATA_WIDTH-1];
                    r_rsp_type <= mem_rdata[TYPE_WIDTH-1:0];
                end
                CAP_VAL: begin
                    r_rsp_value <= mem_rdata;
                    r_rsp_ptr   <= r_ptr;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_ptr   = r_rsp_ptr;
    assign rsp_mark  = r_rsp_mark;
    assign rsp_type  = r_rsp_type;
    assign rsp_value = r_rsp_value;

endmodule
`default_nettype wire

// File: tb/tb_cell_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cell_fetch
//  Purpose  : Self-checking bench for cell_fetch with a synchronous ROM model
//             and a cycle-level behavioural reference of the fetch unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cell_fetch;

    localparam logic [3:0] c_type_number = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_ptr;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_ptr;
    logic        rsp_mark;
    logic [3:0]  rsp_type;
    logic [15:0] rsp_value;

    logic        rand_phase;
    logic        rsp_dir;
    logic        rsp_rand;
    logic        mon_en;

    logic [15:0] rom [65536];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cell_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TYPE_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ptr   (req_ptr),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ptr   (rsp_ptr),
        .rsp_mark  (rsp_mark),
        .rsp_type  (rsp_type),
        .rsp_value (rsp_value)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM: data appears one cycle after the address.
    always @(posedge clk) mem_rdata <= rom[mem_addr];

    always @(posedge clk) cyc <= cyc + 1;

    assign rsp_ready = rand_phase ? rsp_rand : rsp_dir;

    initial begin
        rsp_rand = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rsp_rand = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the unit holds at most one cell. A request seen
    // with the unit free is accepted at the next edge; its cell becomes
    // visible four negedges after the one where acceptance was seen and
    // stays until the consumer takes it. The cell content is read straight
    // from the ROM array using modulo-2^16 pointer arithmetic.
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] ptr;
        logic        mark;
        logic [3:0]  typ;
        logic [15:0] val;
        int          due;
    } cell_t;

    cell_t       pend[$];
    logic        have_acc;
    logic [15:0] acc_ptr;
    int          acc_cyc;
    int          last_acc;
    int          last_hs;
    int          n_acc;
    int          n_rsp;

    always @(negedge clk) begin
        logic        exp_ready;
        logic        exp_valid;
        logic [15:0] exp_addr;
        logic [15:0] nxt;
        cell_t       c;
        if (!rst_n || !mon_en) begin
            pend.delete();
            have_acc = 1'b0;
            acc_ptr  = '0;
            acc_cyc  = 0;
            n_acc    = 0;
            n_rsp    = 0;
        end else begin
            exp_ready = (pend.size() == 0);
            exp_valid = (pend.size() != 0) && (cyc >= pend[0].due);
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid) begin
                check("rsp_ptr",   64'(rsp_ptr),   64'(pend[0].ptr));
                check("rsp_mark",  64'(rsp_mark),  64'(pend[0].mark));
                check("rsp_type",  64'(rsp_type),  64'(pend[0].typ));
                check("rsp_value", 64'(rsp_value), 64'(pend[0].val));
            end
            nxt      = acc_ptr + 16'd1;
            exp_addr = !have_acc ? 16'h0000 : (cyc == acc_cyc + 1) ? acc_ptr : nxt;
            check("mem_addr", 64'(mem_addr), 64'(exp_addr));
            if (exp_valid && rsp_ready) begin
                void'(pend.pop_front());
                n_rsp++;
                last_hs = cyc;
            end
            if (exp_ready && req_valid) begin
                nxt   = req_ptr + 16'd1;
                c.ptr  = req_ptr;
                c.mark = rom[req_ptr][15];
                c.typ  = rom[req_ptr][3:0];
                c.val  = rom[nxt];
                c.due  = cyc + 4;
                pend.push_back(c);
                n_acc++;
                have_acc = 1'b1;
                acc_ptr  = req_ptr;
                acc_cyc  = cyc;
                last_acc = cyc;
            end
        end
    end

    // Present a request and hold it until the unit accepts it. Called and
    // returns at posedge+2 unless chk_addr is set (then returns at a negedge).
    task automatic send(input logic [15:0] p, input bit chk_addr);
        int n;
        logic [15:0] p1;
        n = 0;
        req_valid = 1'b1;
        req_ptr   = p;
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 64'(n), 64'(0));
                break;
            end
        end
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_ptr   = $urandom;
        if (chk_addr) begin
            p1 = p + 16'd1;
            @(negedge clk);
            check("mem_addr_hdr", 64'(mem_addr), 64'(p));
            @(negedge clk);
            check("mem_addr_val", 64'(mem_addr), 64'(p1));
        end
    endtask

    // Wait (bounded) for a negedge with rsp_valid high; report latency from
    // the most recent acceptance.
    task automatic wait_rsp(output int lat);
        int n;
        n   = 0;
        lat = -1;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = cyc - last_acc;
                break;
            end
            n++;
            if (n > 50) begin
                check("rsp_timeout", 64'(n), 64'(0));
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int a0;
        int a1;
        int vcount;

        for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_ptr    = '0;
        rsp_dir    = 1'b1;
        rand_phase = 1'b0;
        mon_en     = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mem_addr",  64'(mem_addr),  64'(0));
        check("rst_rsp_ptr",   64'(rsp_ptr),   64'(0));
        check("rst_rsp_mark",  64'(rsp_mark),  64'(0));
        check("rst_rsp_type",  64'(rsp_type),  64'(0));
        check("rst_rsp_value", 64'(rsp_value), 64'(0));
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #2;

        // Basic fetch of cell 0. Counting the accept edge as the first,
        // rsp_valid is seen after the fourth edge.
        rom[0] = {12'h000, c_type_number};
        rom[1] = 16'h2A2A;
        send(16'h0000, 1'b1);
        wait_rsp(lat);
        check("t1_latency", 64'(lat), 64'(4));
        check("t1_ptr",   64'(rsp_ptr),   64'(16'h0000));
        check("t1_mark",  64'(rsp_mark),  64'(0));
        check("t1_type",  64'(rsp_type),  64'(c_type_number));
        check("t1_value", 64'(rsp_value), 64'(16'h2A2A));
        @(posedge clk);
        #2;

        // Backpressure for 10 cycles with a stray request in the window.
        rsp_dir = 1'b0;
        send(16'h0004, 1'b0);
        wait_rsp(lat);
        @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) begin
            req_valid = (i == 4);
            req_ptr   = 16'h0008;
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            check("bp_req_ready", 64'(req_ready), 64'(0));
            check("bp_value",     64'(rsp_value), 64'(rom[5]));
            @(posedge clk);
            #2;
        end
        req_valid = 1'b1;
        req_ptr   = 16'h0006;
        rsp_dir   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        check("bp_release_to_accept", 64'(last_acc - last_hs), 64'(1));
        check("bp_accepted_ptr",      64'(acc_ptr),            64'(16'h0006));
        repeat (8) @(posedge clk);
        #2;

        // Back-to-back requests with the consumer always ready.
        rom[2] = 16'h8007;
        rom[3] = 16'hBEEF;
        send(16'h0000, 1'b0);
        a0 = last_acc;
        send(16'h0002, 1'b0);
        a1 = last_acc;
        check("b2b_spacing", 64'(a1 - a0), 64'(5));
        wait_rsp(lat);
        check("b2b_ptr",   64'(rsp_ptr),   64'(16'h0002));
        check("b2b_mark",  64'(rsp_mark),  64'(1));
        check("b2b_type",  64'(rsp_type),  64'(7));
        check("b2b_value", 64'(rsp_value), 64'(16'hBEEF));
        @(posedge clk);
        #2;

        // Pointer wrap: value word comes from address 0.
        rom[16'hFFFF] = 16'h8003;
        rom[0]        = 16'h1234;
        send(16'hFFFF, 1'b1);
        wait_rsp(lat);
        check("wrap_mark",  64'(rsp_mark),  64'(1));
        check("wrap_type",  64'(rsp_type),  64'(3));
        check("wrap_value", 64'(rsp_value), 64'(16'h1234));
        @(posedge clk);
        #2;

        // Asynchronous reset while capturing the header.
        rsp_dir = 1'b1;
        send(16'h0010, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'(1));
        check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("arst_mem_addr",  64'(mem_addr),  64'(0));
        check("arst_rsp_ptr",   64'(rsp_ptr),   64'(0));
        check("arst_rsp_mark",  64'(rsp_mark),  64'(0));
        check("arst_rsp_type",  64'(rsp_type),  64'(0));
        check("arst_rsp_value", 64'(rsp_value), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) vcount++;
        end
        check("arst_no_rsp", 64'(vcount), 64'(0));
        @(posedge clk);
        #2;

        // Randomized traffic with random consumer backpressure.
        for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
        rand_phase = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            send(16'($urandom), 1'b0);
        end
        rand_phase = 1'b0;
        rsp_dir    = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("rand_accepts",   64'(n_acc),        64'(1000));
        check("rand_responses", 64'(n_rsp),        64'(1000));
        check("rand_drained",   64'(pend.size()),  64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
